// File: rtl/traffic_pkg.sv
// Shared types and default phase durations for the two-road intersection controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN,
    NS_YELLOW,
    ALLRED_A,
    EW_GREEN,
    EW_YELLOW,
    ALLRED_B,
    WALK
  } xing_state_t;

  typedef struct packed {
    logic r;
    logic y;
    logic g;
  } lamp_t;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_T_GREEN  = 10;
  localparam int DEF_T_YELLOW = 4;
  localparam int DEF_T_ALLRED = 2;
  localparam int DEF_T_WALK   = 6;

  localparam lamp_t LAMP_RED = '{r: 1'b1, y: 1'b0, g: 1'b0};

  // Red whenever the road is neither green nor yellow, so each road is always one-hot.
  function automatic lamp_t lamp_decode(input logic green, input logic yellow);
    lamp_t l;
    l.g = green;
    l.y = yellow & ~green;
    l.r = ~(green | yellow);
    return l;
  endfunction

endpackage

// File: rtl/traffic_xing_ctrl_phase_timer.sv
// Phase duration counter: clears on restart, otherwise counts up; done flags the last
// clock of a phase of length limit.
module phase_timer
  import traffic_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q + ONE;
    if (restart) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign done = (count_q == (limit - ONE));

endmodule

// File: rtl/traffic_xing_ctrl.sv
// Two-road intersection controller sequencing NS/EW green, yellow and all-red phases
// with registered lamp outputs. Define TRAFFIC_PED_EN to build the pedestrian walk phase.
module traffic_xing_ctrl
  import traffic_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int T_GREEN  = DEF_T_GREEN,
  parameter int T_YELLOW = DEF_T_YELLOW,
  parameter int T_ALLRED = DEF_T_ALLRED,
  parameter int T_WALK   = DEF_T_WALK
) (
  input  logic clk,
  input  logic rst,
`ifdef TRAFFIC_PED_EN
  input  logic ped_req,
`endif
  output logic ns_r,
  output logic ns_y,
  output logic ns_g,
  output logic ew_r,
  output logic ew_y,
  output logic ew_g,
  output logic walk,
  output logic ped_pending
);

  localparam int T_MAX = (1 << CNT_W) - 1;
  localparam bit DUR_OK = (T_GREEN  >= 1) && (T_GREEN  <= T_MAX) &&
                          (T_YELLOW >= 1) && (T_YELLOW <= T_MAX) &&
                          (T_ALLRED >= 1) && (T_ALLRED <= T_MAX) &&
                          (T_WALK   >= 1) && (T_WALK   <= T_MAX);

  if (!DUR_OK) begin : g_dur_chk
    $error("traffic_xing_ctrl: every duration must lie in 1 .. 2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] LIM_GREEN  = CNT_W'(T_GREEN);
  localparam logic [CNT_W-1:0] LIM_YELLOW = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] LIM_ALLRED = CNT_W'(T_ALLRED);
  localparam logic [CNT_W-1:0] LIM_WALK   = CNT_W'(T_WALK);

  xing_state_t      state_q;
  xing_state_t      state_d;
  logic [CNT_W-1:0] limit;
  logic             done;
  logic             restart;
  logic             ped_go;
  lamp_t            ns_q;
  lamp_t            ew_q;

  always_comb begin
    case (state_q)
      NS_GREEN, EW_GREEN:   limit = LIM_GREEN;
      NS_YELLOW, EW_YELLOW: limit = LIM_YELLOW;
      WALK:                 limit = LIM_WALK;
      default:              limit = LIM_ALLRED;
    endcase
  end

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .limit   (limit),
    .done    (done)
  );

  always_comb begin
    state_d = state_q;
    if (done) begin
      case (state_q)
        NS_GREEN:  state_d = NS_YELLOW;
        NS_YELLOW: state_d = ALLRED_A;
        ALLRED_A:  state_d = EW_GREEN;
        EW_GREEN:  state_d = EW_YELLOW;
        EW_YELLOW: state_d = ALLRED_B;
        ALLRED_B:  state_d = ped_go ? WALK : NS_GREEN;
        WALK:      state_d = ALLRED_B;
        default:   state_d = ALLRED_B;
      endcase
    end
    restart = (state_d != state_q);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ALLRED_B;
    else     state_q <= state_d;
  end

  // Lamp registers: outputs follow the state one clock later.
  always_ff @(posedge clk) begin
    if (rst) begin
      ns_q <= LAMP_RED;
      ew_q <= LAMP_RED;
    end else begin
      ns_q <= lamp_decode(state_q == NS_GREEN, state_q == NS_YELLOW);
      ew_q <= lamp_decode(state_q == EW_GREEN, state_q == EW_YELLOW);
    end
  end

  assign ns_r = ns_q.r;
  assign ns_y = ns_q.y;
  assign ns_g = ns_q.g;
  assign ew_r = ew_q.r;
  assign ew_y = ew_q.y;
  assign ew_g = ew_q.g;

`ifdef TRAFFIC_PED_EN
  logic pend_q;
  logic pend_d;
  logic after_walk_q;
  logic after_walk_d;
  logic walk_q;
  logic pend_out_q;

  // The all-red that follows a walk always hands over to north-south traffic, so a
  // held request cannot starve the roads; it is served on the next cycle instead.
  assign ped_go = (pend_q | ped_req) & ~after_walk_q;

  always_comb begin
    pend_d = pend_q | ped_req;
    if ((state_d == WALK) && (state_q != WALK)) pend_d = 1'b0;
    after_walk_d = 1'b0;
    if (state_q == WALK)          after_walk_d = 1'b1;
    else if (state_q == ALLRED_B) after_walk_d = after_walk_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q       <= 1'b0;
      after_walk_q <= 1'b0;
      walk_q       <= 1'b0;
      pend_out_q   <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      after_walk_q <= after_walk_d;
      walk_q       <= (state_q == WALK);
      pend_out_q   <= pend_q;
    end
  end

  assign walk        = walk_q;
  assign ped_pending = pend_out_q;
`else
  assign ped_go      = 1'b0;
  assign walk        = 1'b0;
  assign ped_pending = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_xing_ctrl.sv
// Directed bench for traffic_xing_ctrl: default-parameter instance plus a minimum-duration
// instance; pedestrian scenarios are exercised when TRAFFIC_PED_EN is defined.
module tb_traffic_xing_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ped_req = 1'b0;
  logic ped_req_min = 1'b0;

  logic ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk, ped_pending;
  logic m_ns_r, m_ns_y, m_ns_g, m_ew_r, m_ew_y, m_ew_g, m_walk, m_ped_pending;

  int n_checks = 0;
  int n_errors = 0;
  int e = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  traffic_xing_ctrl dut (
    .clk         (clk),
    .rst         (rst),
`ifdef TRAFFIC_PED_EN
    .ped_req     (ped_req),
`endif
    .ns_r        (ns_r),
    .ns_y        (ns_y),
    .ns_g        (ns_g),
    .ew_r        (ew_r),
    .ew_y        (ew_y),
    .ew_g        (ew_g),
    .walk        (walk),
    .ped_pending (ped_pending)
  );

  traffic_xing_ctrl #(
    .CNT_W    (2),
    .T_GREEN  (1),
    .T_YELLOW (1),
    .T_ALLRED (1),
    .T_WALK   (1)
  ) dut_min (
    .clk         (clk),
    .rst         (rst),
`ifdef TRAFFIC_PED_EN
    .ped_req     (ped_req_min),
`endif
    .ns_r        (m_ns_r),
    .ns_y        (m_ns_y),
    .ns_g        (m_ns_g),
    .ew_r        (m_ew_r),
    .ew_y        (m_ew_y),
    .ew_g        (m_ew_g),
    .walk        (m_walk),
    .ped_pending (m_ped_pending)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  task automatic adv_to(input int t);
    while (e < t) adv(1);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    ped_req = 1'b0;
    adv(2);
    rst = 1'b0;
    e = 0;
  endtask

  function automatic logic unsafe(input logic r1, input logic y1, input logic g1,
                                  input logic r2, input logic y2, input logic g2,
                                  input logic w);
    return ((int'(r1) + int'(y1) + int'(g1)) != 1) ||
           ((int'(r2) + int'(y2) + int'(g2)) != 1) ||
           (!r1 && !r2) ||
           (w && !(r1 && r2));
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("safe_main", unsafe(ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk), 1'b0);
      check_eq("safe_min", unsafe(m_ns_r, m_ns_y, m_ns_g, m_ew_r, m_ew_y, m_ew_g, m_walk), 1'b0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    // Reset state
    rst = 1'b1;
    adv(2);
    mon_en = 1'b1;
    check_eq("rst_ns_r", ns_r, 1);
    check_eq("rst_ew_r", ew_r, 1);
    check_eq("rst_ns_g", ns_g, 0);
    check_eq("rst_ew_y", ew_y, 0);
    check_eq("rst_walk", walk, 0);
    check_eq("rst_pend", ped_pending, 0);
    check_eq("min_rst_ns_r", m_ns_r, 1);
    check_eq("min_rst_pend", m_ped_pending, 0);
    rst = 1'b0;
    e = 0;

    // Nominal sequence from reset release, with the minimum-duration instance alongside
    adv_to(2);
    check_eq("ns_g_e2", ns_g, 0);
    check_eq("min_ns_g_e2", m_ns_g, 1);
    adv_to(3);
    check_eq("ns_g_e3", ns_g, 1);
    check_eq("ns_r_e3", ns_r, 0);
    check_eq("ew_r_e3", ew_r, 1);
    check_eq("min_ns_y_e3", m_ns_y, 1);
    adv_to(4);
    check_eq("min_allred_ns_r_e4", m_ns_r, 1);
    check_eq("min_allred_ew_r_e4", m_ew_r, 1);
    adv_to(5);
    check_eq("min_ew_g_e5", m_ew_g, 1);
    adv_to(8);
    check_eq("min_ns_g_e8", m_ns_g, 1);
    adv_to(12);
    check_eq("ns_g_e12", ns_g, 1);
    adv_to(13);
    check_eq("ns_g_e13", ns_g, 0);
    check_eq("ns_y_e13", ns_y, 1);
    adv_to(14);
    check_eq("min_ns_g_e14", m_ns_g, 1);
    adv_to(16);
    check_eq("ns_y_e16", ns_y, 1);
    adv_to(17);
    check_eq("ns_y_e17", ns_y, 0);
    check_eq("ns_r_e17", ns_r, 1);
    check_eq("ew_r_e17", ew_r, 1);
    adv_to(18);
    check_eq("ew_g_e18", ew_g, 0);
    adv_to(19);
    check_eq("ew_g_e19", ew_g, 1);
    check_eq("ns_r_e19", ns_r, 1);
    adv_to(34);
    check_eq("ns_g_e34", ns_g, 0);
    adv_to(35);
    check_eq("ns_g_e35_period", ns_g, 1);

`ifdef TRAFFIC_PED_EN
    // Pulse during NS_GREEN: walk after the next ALLRED_B, 40-clock cycle
    ped_req = 1'b1;
    adv(1);
    ped_req = 1'b0;
    check_eq("pulse_pend_e36", ped_pending, 0);
    adv_to(37);
    check_eq("pulse_pend_e37", ped_pending, 1);
    adv_to(66);
    check_eq("pulse_walk_e66", walk, 0);
    check_eq("pulse_pend_e66", ped_pending, 1);
    adv_to(67);
    check_eq("pulse_walk_e67", walk, 1);
    check_eq("pulse_pend_e67", ped_pending, 0);
    check_eq("pulse_ns_r_e67", ns_r, 1);
    check_eq("pulse_ew_r_e67", ew_r, 1);
    adv_to(72);
    check_eq("pulse_walk_e72", walk, 1);
    adv_to(73);
    check_eq("pulse_walk_e73", walk, 0);
    adv_to(74);
    check_eq("pulse_ns_g_e74", ns_g, 0);
    adv_to(75);
    check_eq("pulse_ns_g_e75", ns_g, 1);
`else
    adv_to(66);
    check_eq("cyc3_ns_g_e66", ns_g, 0);
    adv_to(67);
    check_eq("cyc3_ns_g_e67", ns_g, 1);
    check_eq("cyc3_walk_e67", walk, 0);
    check_eq("cyc3_pend_e67", ped_pending, 0);
`endif

    // Reset in the middle of EW_GREEN, with a latched request in the pedestrian build
    reset_dut();
    adv_to(20);
`ifdef TRAFFIC_PED_EN
    ped_req = 1'b1;
    adv(1);
    ped_req = 1'b0;
`endif
    adv_to(22);
    check_eq("mid_ew_g_e22", ew_g, 1);
`ifdef TRAFFIC_PED_EN
    check_eq("mid_pend_e22", ped_pending, 1);
`endif
    rst = 1'b1;
    adv(1);
    check_eq("mid_rst_ns_r", ns_r, 1);
    check_eq("mid_rst_ew_r", ew_r, 1);
    check_eq("mid_rst_ew_g", ew_g, 0);
    check_eq("mid_rst_pend", ped_pending, 0);
    check_eq("mid_rst_walk", walk, 0);
    rst = 1'b0;
    e = 0;
    adv_to(2);
    check_eq("mid_ns_g_e2", ns_g, 0);
    adv_to(3);
    check_eq("mid_ns_g_e3", ns_g, 1);
    adv_to(34);
    check_eq("mid_ns_g_e34", ns_g, 0);
    adv_to(35);
    check_eq("mid_ns_g_e35", ns_g, 1);
    check_eq("mid_walk_e35", walk, 0);

`ifdef TRAFFIC_PED_EN
    // Held request: one walk per cycle, pending re-latches a clock after walk rises
    reset_dut();
    ped_req = 1'b1;
    adv_to(2);
    check_eq("hold_walk_e2", walk, 0);
    check_eq("hold_pend_e2", ped_pending, 1);
    adv_to(3);
    check_eq("hold_walk_e3", walk, 1);
    check_eq("hold_pend_e3", ped_pending, 0);
    adv_to(4);
    check_eq("hold_pend_e4", ped_pending, 1);
    adv_to(8);
    check_eq("hold_walk_e8", walk, 1);
    adv_to(9);
    check_eq("hold_walk_e9", walk, 0);
    adv_to(11);
    check_eq("hold_ns_g_e11", ns_g, 1);
    adv_to(42);
    check_eq("hold_walk_e42", walk, 0);
    adv_to(43);
    check_eq("hold_walk_e43", walk, 1);
    check_eq("hold_pend_e43", ped_pending, 0);
    adv_to(44);
    check_eq("hold_pend_e44", ped_pending, 1);
    ped_req = 1'b0;

    // Pulse on the last cycle of ALLRED_B: immediate walk, nothing left pending
    reset_dut();
    adv_to(1);
    ped_req = 1'b1;
    adv(1);
    ped_req = 1'b0;
    check_eq("last_pend_e2", ped_pending, 0);
    adv_to(3);
    check_eq("last_walk_e3", walk, 1);
    check_eq("last_pend_e3", ped_pending, 0);
    adv_to(4);
    check_eq("last_pend_e4", ped_pending, 0);
    adv_to(8);
    check_eq("last_walk_e8", walk, 1);
    adv_to(9);
    check_eq("last_walk_e9", walk, 0);
    adv_to(11);
    check_eq("last_ns_g_e11", ns_g, 1);
`endif

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/traffic_xing_ctrl.md
# traffic_xing_ctrl

Parametrised two-road intersection controller, successor to the single-road timed traffic-light FSM. Sequences north-south and east-west lamp sets through green, yellow and all-red clearance phases with per-phase durations set by parameters. Optionally serves latched pedestrian requests with a dedicated walk phase. Sits at the top of the signalling datapath and drives the lamp output registers directly.

## Interface
- `CNT_W`, 8: phase counter width.
- `T_GREEN`, 10: green duration in clocks (each road).
- `T_YELLOW`, 4: yellow duration in clocks.
- `T_ALLRED`, 2: all-red clearance duration in clocks.
- `T_WALK`, 6: pedestrian walk duration in clocks (used only with `TRAFFIC_PED_EN`).
- Clocking and reset (already decided): one clock; reset is synchronous and active-high.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ped_req` in 1: pedestrian request; a one-cycle pulse or a held level. Only present with `TRAFFIC_PED_EN`.
- `ns_r`, `ns_y`, `ns_g` out 1 each: north-south lamps, registered.
- `ew_r`, `ew_y`, `ew_g` out 1 each: east-west lamps, registered.
- `walk` out 1: pedestrian walk lamp, registered. Tied to 0 without `TRAFFIC_PED_EN`.
- `ped_pending` out 1: a latched request is awaiting service, registered. Tied to 0 without `TRAFFIC_PED_EN`.

## Operation
- States:
  - `NS_GREEN`
  - `NS_YELLOW`
  - `ALLRED_A`
  - `EW_GREEN`
  - `EW_YELLOW`
  - `ALLRED_B`
  - `WALK`
- Nominal order:
  - `ALLRED_B` → `NS_GREEN` → `NS_YELLOW` → `ALLRED_A` → `EW_GREEN` → `EW_YELLOW` → `ALLRED_B`.
- Phase counter:
  - Clears to 0 on every state transition and increments each clock otherwise.
  - The state exits when `count == T_x-1`, so each state occupies exactly `T_x` clocks.
- Pedestrian phase:
  - On the last cycle of `ALLRED_B`, if pending (the latched flag OR `ped_req` in that cycle), go to `WALK`. Otherwise go to `NS_GREEN`.
  - `WALK` returns to `ALLRED_B`. Pending is cleared on entry to `WALK`, so the second `ALLRED_B` proceeds to `NS_GREEN`.
- Pending flag:
  - Set by `ped_req`. Cleared only on entry to `WALK`.
  - If `ped_req` is high in the same cycle as entry to `WALK`, the flag stays cleared, because that request is served by this walk.
  - Requests arriving during `WALK` set the flag for the next cycle.
- Lamp decode:
  - `*_g` and `*_y` are asserted only in that road's green and yellow states. That road's `*_r` is asserted in all other states.
  - `walk` is asserted in `WALK` only. Both `*_r` are asserted in `WALK`.
  - At most one of r/y/g is high per road at any time. Both roads are never non-red at the same time.
- Duration parameters must satisfy 1 ≤ T ≤ 2**CNT_W−1. Check this with an elaboration-time assertion.

## Timing
- Reset values:
  - State `ALLRED_B`, count 0, pending 0.
  - `ns_r = ew_r = 1`; all other outputs 0.
- Reset mid-phase behaves identically and takes effect at the next edge; a latched request is discarded.
- Outputs are registered, so they lag the state by exactly one clock.
- Edge numbering: edge 1 is the first rising edge with `rst` low.
  - `ns_g` rises after edge `T_ALLRED+1`.
  - With defaults, `ns_g` rises after edge 3.
- Full cycle length:
  - Without walk: 2·(T_GREEN+T_YELLOW+T_ALLRED) = 32 clocks (defaults).
  - With walk: add T_WALK+T_ALLRED, giving 40 clocks.
- Worst-case request latency: a request just after the `ALLRED_B` decision waits one full cycle.
- The counter never wraps, because the exit compare fires before 2**CNT_W−1.

## Configuration
- `TRAFFIC_PED_EN` defined:
  - The `ped_req` port, pending flag and `WALK` state are present.
- `TRAFFIC_PED_EN` undefined:
  - The `ped_req` port is absent and `WALK` is unreachable.
  - `walk` and `ped_pending` are constant 0.
  - `ALLRED_B` always proceeds to `NS_GREEN`.

## Structure
- `traffic_pkg`:
  - State enum `xing_state_t`.
  - A lamp-bundle struct (r, y, g).
  - Default duration localparams.
- Sub-module `phase_timer`:
  - Parameter `CNT_W`.
  - Inputs: `clk`, `rst`, `restart`, `limit`.
  - Output: `done`, asserted when `count == limit-1`.
- The top level holds the FSM, the pending flag and the output registers.

## Test plan
- Reset release, no requests, defaults:
  - `ns_g` high from edge 3 to edge 12.
  - `ns_y` high from edge 13 to edge 16.
  - `ew_g` high from edge 19.
  - The period is 32 clocks.
- `ped_req` pulse during `NS_GREEN`:
  - `ped_pending` goes high the next clock.
  - After `EW_YELLOW` and `ALLRED_B`, `walk` is high for 6 clocks.
  - `ped_pending` drops as `walk` rises.
  - That cycle's period is 40 clocks.
- `ped_req` held high continuously:
  - A walk phase occurs every cycle.
  - `ped_pending` re-asserts one clock after `walk` rises.
- `ped_req` pulse on the last cycle of `ALLRED_B`:
  - `WALK` is entered immediately.
  - `ped_pending` stays 0 afterwards.
- `rst` asserted mid-`EW_GREEN` with a pending request:
  - The next clock shows both reds high, `ped_pending` = 0 and `walk` = 0.
  - The sequence restarts as in the first scenario.
- Override `T_GREEN=1`, `T_YELLOW=1`, `T_ALLRED=1`, `CNT_W=2`:
  - Every state lasts 1 clock.
  - The period is 6 clocks.
  - A continuous safety check (never both roads non-red, one-hot lamps per road) holds throughout.
